ssd_driver: RTL and testbench

Drives the board's 4-digit seven-segment display from the CPU's 13-bit `ssd` output. It converts the unsigned binary value to four BCD digits with a sequential double-dabble engine, one shift per clock. It then time-multiplexes the digits onto shared active-low segment and anode lines. It sits at the board top level, downstream of `RISCV_CPU`.

---
 rtl/ssd_driver.sv | 140 ++++++++++++++
 tb/tb_ssd_driver.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ssd_driver.sv
// rtl/ssd_driver.sv - 13-bit binary to 4-digit multiplexed seven-segment driver
module ssd_driver #(
  parameter int REFRESH_CYCLES = 100000,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] value,
  output logic [3:0]  anode,
  output logic [6:0]  segments,
  output logic        busy
);

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         r_state;
  logic [12:0]    r_captured;
  logic [12:0]    r_shreg;
  logic [15:0]    r_bcd;
  logic [3:0]     r_cnt;
  logic [15:0]    r_disp;
  logic           r_busy;
  logic [RW-1:0]  r_refresh;
  logic [1:0]     r_dig;

  logic [15:0]    w_adj;
  logic [28:0]    w_shift;
  logic [3:0]     w_nib;
  logic           w_upper_zero;
  logic           w_blank;

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) begin
        w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  assign w_shift = {w_adj, r_shreg} << 1;

  // Converter FSM: capture a changed value, shift 13 times, then publish to the display
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_captured <= '0;
      r_shreg    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_disp     <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (value != r_captured) begin
            r_captured <= value;
            r_shreg    <= value;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          {r_bcd, r_shreg} <= w_shift;
          r_cnt            <= r_cnt + 4'd1;
          if (r_cnt == 4'd12) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_disp  <= r_bcd;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Refresh timer: advance to the next digit every REFRESH_CYCLES clocks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_refresh <= '0;
      r_dig     <= '0;
    end else if (r_refresh == REF_LAST) begin
      r_refresh <= '0;
      r_dig     <= r_dig + 2'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  assign w_nib = r_disp[{r_dig, 2'b00} +: 4];

  // Leading-zero test: the selected digit and all digits above it are zero
  always_comb begin
    w_upper_zero = 1'b0;
    case (r_dig)
      2'd1:    w_upper_zero = (r_disp[15:4]  == 12'd0);
      2'd2:    w_upper_zero = (r_disp[15:8]  == 8'd0);
      2'd3:    w_upper_zero = (r_disp[15:12] == 4'd0);
      default: w_upper_zero = 1'b0;
    endcase
  end

  assign w_blank = BLANK_LZ && w_upper_zero;

  // Active-low segment decode {g,f,e,d,c,b,a}; non-decimal nibbles go dark
  always_comb begin
    segments = 7'b1111111;
    if (!w_blank) begin
      case (w_nib)
        4'd0:    segments = 7'b1000000;
        4'd1:    segments = 7'b1111001;
        4'd2:    segments = 7'b0100100;
        4'd3:    segments = 7'b0110000;
        4'd4:    segments = 7'b0011001;
        4'd5:    segments = 7'b0010010;
        4'd6:    segments = 7'b0000010;
        4'd7:    segments = 7'b1111000;
        4'd8:    segments = 7'b0000000;
        4'd9:    segments = 7'b0010000;
        default: segments = 7'b1111111;
      endcase
    end
  end

  assign anode = ~(4'b0001 << r_dig);
  assign busy  = r_busy;

endmodule

// File: tb/tb_ssd_driver.sv
// tb/tb_ssd_driver.sv - directed scoreboard bench for ssd_driver
module tb_ssd_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [12:0] value = '0;
  logic [3:0]  anode;
  logic [6:0]  segments;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc;
  int q[$];
  int shown = 0;

  ssd_driver #(.REFRESH_CYCLES(4), .BLANK_LZ(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .anode    (anode),
    .segments (segments),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference refresh phase: clocks since reset release
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(int v, int k);
    int pw[4] = '{1, 10, 100, 1000};
    if (k > 0 && v < pw[k]) return 7'b1111111;
    return seg_of((v / pw[k]) % 10);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(string tag, int v);
    int d;
    logic [3:0] ea;
    d = (cyc / 4) % 4;
    ea = 4'b1111;
    ea[d] = 1'b0;
    chk({tag, " anode"}, 32'(anode), 32'(ea));
    chk({tag, " seg"}, 32'(segments), 32'(exp_seg(v, d)));
  endtask

  task automatic frame(string tag, int v);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk_disp(tag, v);
    end
  endtask

  task automatic conv(string tag, int change_at, int newv);
    int w;
    int n;
    @(negedge clk);
    w = 1;
    while (!busy && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " start"}, 32'(w), 32'd1);
    n = 0;
    while (busy && n < 40) begin
      n++;
      chk_disp({tag, " hold"}, shown);
      if (n == change_at) begin
        value = 13'(newv);
        q.push_back(newv);
      end
      @(negedge clk);
    end
    chk({tag, " busy_len"}, 32'(n), 32'd14);
    chk({tag, " queue"}, 32'(q.size() > 0), 32'd1);
    if (q.size() > 0) shown = q.pop_front();
    chk_disp({tag, " done"}, shown);
  endtask

  initial begin
    value = 13'd5555;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst anode", 32'(anode), 32'hE);
    chk("rst seg", 32'(segments), 32'h40);

    value = 13'd0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("zero idle busy", 32'(busy), 32'd0);
    end
    frame("zero", 0);

    value = 13'd1234;
    q.push_back(1234);
    conv("c1234", 0, 0);
    frame("f1234", 1234);

    value = 13'd8191;
    q.push_back(8191);
    conv("c8191", 0, 0);
    frame("f8191", 8191);

    value = 13'd7;
    q.push_back(7);
    conv("c7", 0, 0);
    frame("f7", 7);

    value = 13'd0;
    q.push_back(0);
    conv("c0", 0, 0);
    frame("f0", 0);

    value = 13'd1234;
    q.push_back(1234);
    conv("c1234b", 5, 42);
    conv("c42", 0, 0);
    frame("f42", 42);

    value = 13'd1234;
    @(negedge clk);
    chk("abort start", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort anode", 32'(anode), 32'hE);
    chk("abort seg", 32'(segments), 32'h40);
    shown = 0;
    @(negedge clk);
    reset = 1'b1;
    q.push_back(1234);
    conv("crst", 0, 0);
    frame("frst", 1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
